// File: rtl/laser_pkt_responder.sv
// laser_pkt_responder
//   Receive-side protocol engine at the far end of the laser link. Frames
//   START (0xcc, 512 bytes) and STOP (0x55, 6 bytes) packets from the laser
//   receiver and buffers the payload. It forwards the payload to the FTDI
//   write port, then answers over the laser transmitter:
//     ACK  (0x11 x4) after a START packet,
//     DONE (0xaa x2) after a STOP packet,
//     FAIL (0xbb x4) on an inter-byte timeout or a rejected checksum.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   rx_valid, rx_data     1-cycle strobe with a received byte
//   wr_valid, wr_data     payload byte offered to FTDI, held until wr_ready
//   wr_ready              FTDI accepts (transfer on wr_valid & wr_ready)
//   tx_en, tx_data        response byte request, tx_data constant per response
//   tx_done               1-cycle strobe: current response byte has been sent
//   pkt_ok, pkt_fail      1-cycle pulses on the first cycle of a response
//   session_done          sticky after a DONE response, cleared by a START header
//
// Build option
//   LASER_RESP_CHECKSUM_EN: the last packet byte is the XOR of all earlier
//   bytes (header included). A mismatch answers FAIL, and the checksum byte
//   is never forwarded.

module laser_pkt_responder (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       wr_valid,
   output logic [7:0] wr_data,
   input  logic       wr_ready,
   output logic       tx_en,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic       pkt_ok,
   output logic       pkt_fail,
   output logic       session_done
);

   localparam logic [9:0] START_LEN = 10'd512;
   localparam logic [9:0] STOP_LEN  = 10'd6;
   localparam logic [9:0] TO_LAST   = 10'd1023;  // 1024 idle cycles, counted from 0
   localparam logic [7:0] HDR_START = 8'hcc;
   localparam logic [7:0] HDR_STOP  = 8'h55;
   localparam logic [7:0] ACK_BYTE  = 8'h11;
   localparam logic [7:0] DONE_BYTE = 8'haa;
   localparam logic [7:0] FAIL_BYTE = 8'hbb;
   localparam logic [1:0] ACK_LAST  = 2'd3;
   localparam logic [1:0] FAIL_LAST = 2'd3;
   localparam logic [1:0] DONE_LAST = 2'd1;
`ifdef LASER_RESP_CHECKSUM_EN
   localparam logic [9:0] TRAILER   = 10'd2;     // header + checksum are not forwarded
`else
   localparam logic [9:0] TRAILER   = 10'd1;     // only the header is not forwarded
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_CHECK = 3'd2,
      S_DRAIN = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  exp_len_q, exp_len_d;
   logic        is_stop_q, is_stop_d;
   logic [9:0]  byte_ct_q, byte_ct_d;
   logic [9:0]  to_ct_q, to_ct_d;
   logic [8:0]  rd_ptr_q, rd_ptr_d;
   logic [1:0]  resp_ct_q, resp_ct_d;
   logic        wr_valid_q, wr_valid_d;
   logic [7:0]  wr_data_q;
   logic        tx_en_q, tx_en_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        pkt_ok_q, pkt_ok_d;
   logic        pkt_fail_q, pkt_fail_d;
   logic        session_done_q, session_done_d;
`ifdef LASER_RESP_CHECKSUM_EN
   logic [7:0]  xor_q, xor_d;
`endif

   logic        mem_we_s;
   logic        mem_re_s;
   logic [8:0]  mem_raddr_s;
   logic [8:0]  mem_waddr_s;
   logic [9:0]  drn_len_s;
   logic [1:0]  resp_last_s;
   logic [7:0]  buf_mem [0:510];

   // byte_ct counts the header as byte 1, so payload byte n lands at n-1.
   assign mem_waddr_s = byte_ct_q[8:0] - 9'd1;
   assign drn_len_s   = exp_len_q - TRAILER;

   // Index of the final byte of the response currently being sent.
   always_comb begin
      case (tx_data_q)
         DONE_BYTE: resp_last_s = DONE_LAST;
         ACK_BYTE:  resp_last_s = ACK_LAST;
         default:   resp_last_s = FAIL_LAST;
      endcase
   end

   // Next-state and next-output logic for the framing/response FSM.
   always_comb begin
      state_d        = state_q;
      exp_len_d      = exp_len_q;
      is_stop_d      = is_stop_q;
      byte_ct_d      = byte_ct_q;
      to_ct_d        = to_ct_q;
      rd_ptr_d       = rd_ptr_q;
      resp_ct_d      = resp_ct_q;
      wr_valid_d     = wr_valid_q;
      tx_en_d        = tx_en_q;
      tx_data_d      = tx_data_q;
      pkt_ok_d       = 1'b0;
      pkt_fail_d     = 1'b0;
      session_done_d = session_done_q;
`ifdef LASER_RESP_CHECKSUM_EN
      xor_d          = xor_q;
`endif
      mem_we_s       = 1'b0;
      mem_re_s       = 1'b0;
      mem_raddr_s    = 9'd0;
      case (state_q)
         S_IDLE: begin
            if (rx_valid && ((rx_data == HDR_START) || (rx_data == HDR_STOP))) begin
               state_d   = S_RECV;
               is_stop_d = (rx_data == HDR_STOP);
               exp_len_d = (rx_data == HDR_STOP) ? STOP_LEN : START_LEN;
               byte_ct_d = 10'd1;
               to_ct_d   = 10'd0;
`ifdef LASER_RESP_CHECKSUM_EN
               xor_d     = rx_data;
`endif
               if (rx_data == HDR_START) begin
                  session_done_d = 1'b0;
               end else begin
                  session_done_d = session_done_q;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RECV: begin
            // A byte arriving on the timeout cycle still counts.
            if (rx_valid) begin
               mem_we_s  = 1'b1;
               byte_ct_d = byte_ct_q + 10'd1;
               to_ct_d   = 10'd0;
`ifdef LASER_RESP_CHECKSUM_EN
               xor_d     = xor_q ^ rx_data;
`endif
               if ((byte_ct_q + 10'd1) == exp_len_q) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_RECV;
               end
            end else if (to_ct_q == TO_LAST) begin
               state_d    = S_RESP;
               tx_en_d    = 1'b1;
               tx_data_d  = FAIL_BYTE;
               resp_ct_d  = 2'd0;
               pkt_fail_d = 1'b1;
            end else begin
               to_ct_d = to_ct_q + 10'd1;
            end
         end
         S_CHECK: begin
`ifdef LASER_RESP_CHECKSUM_EN
            // XOR over all bytes including the checksum is zero when it matches.
            if (xor_q != 8'h00) begin
               state_d    = S_RESP;
               tx_en_d    = 1'b1;
               tx_data_d  = FAIL_BYTE;
               resp_ct_d  = 2'd0;
               pkt_fail_d = 1'b1;
            end else begin
               state_d     = S_DRAIN;
               mem_re_s    = 1'b1;
               mem_raddr_s = 9'd0;
               rd_ptr_d    = 9'd1;
               wr_valid_d  = 1'b1;
            end
`else
            state_d     = S_DRAIN;
            mem_re_s    = 1'b1;
            mem_raddr_s = 9'd0;
            rd_ptr_d    = 9'd1;
            wr_valid_d  = 1'b1;
`endif
         end
         S_DRAIN: begin
            // rd_ptr_q is the number of bytes already loaded into wr_data.
            if (wr_valid_q && wr_ready) begin
               if ({1'b0, rd_ptr_q} == drn_len_s) begin
                  wr_valid_d = 1'b0;
                  state_d    = S_RESP;
                  tx_en_d    = 1'b1;
                  tx_data_d  = is_stop_q ? DONE_BYTE : ACK_BYTE;
                  resp_ct_d  = 2'd0;
                  pkt_ok_d   = 1'b1;
               end else begin
                  mem_re_s    = 1'b1;
                  mem_raddr_s = rd_ptr_q;
                  rd_ptr_d    = rd_ptr_q + 9'd1;
               end
            end else begin
               wr_valid_d = wr_valid_q;
            end
         end
         S_RESP: begin
            if (tx_done) begin
               if (resp_ct_q == resp_last_s) begin
                  state_d   = S_IDLE;
                  tx_en_d   = 1'b0;
                  tx_data_d = 8'h00;
                  if (tx_data_q == DONE_BYTE) begin
                     session_done_d = 1'b1;
                  end else begin
                     session_done_d = session_done_q;
                  end
               end else begin
                  resp_ct_d = resp_ct_q + 2'd1;
               end
            end else begin
               resp_ct_d = resp_ct_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         exp_len_q      <= 10'd0;
         is_stop_q      <= 1'b0;
         byte_ct_q      <= 10'd0;
         to_ct_q        <= 10'd0;
         rd_ptr_q       <= 9'd0;
         resp_ct_q      <= 2'd0;
         wr_valid_q     <= 1'b0;
         tx_en_q        <= 1'b0;
         tx_data_q      <= 8'h00;
         pkt_ok_q       <= 1'b0;
         pkt_fail_q     <= 1'b0;
         session_done_q <= 1'b0;
`ifdef LASER_RESP_CHECKSUM_EN
         xor_q          <= 8'h00;
`endif
      end else begin
         state_q        <= state_d;
         exp_len_q      <= exp_len_d;
         is_stop_q      <= is_stop_d;
         byte_ct_q      <= byte_ct_d;
         to_ct_q        <= to_ct_d;
         rd_ptr_q       <= rd_ptr_d;
         resp_ct_q      <= resp_ct_d;
         wr_valid_q     <= wr_valid_d;
         tx_en_q        <= tx_en_d;
         tx_data_q      <= tx_data_d;
         pkt_ok_q       <= pkt_ok_d;
         pkt_fail_q     <= pkt_fail_d;
         session_done_q <= session_done_d;
`ifdef LASER_RESP_CHECKSUM_EN
         xor_q          <= xor_d;
`endif
      end
   end

   // Payload buffer write port; contents need no reset.
   always_ff @(posedge clock) begin
      if (mem_we_s) begin
         buf_mem[mem_waddr_s] <= rx_data;
      end
   end

   // Registered buffer read straight into wr_data, which holds during stalls.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_data_q <= 8'h00;
      end else if (mem_re_s) begin
         wr_data_q <= buf_mem[mem_raddr_s];
      end
   end

   assign wr_valid     = wr_valid_q;
   assign wr_data      = wr_data_q;
   assign tx_en        = tx_en_q;
   assign tx_data      = tx_data_q;
   assign pkt_ok       = pkt_ok_q;
   assign pkt_fail     = pkt_fail_q;
   assign session_done = session_done_q;

endmodule

// File: tb/tb_laser_pkt_responder.sv
// Testbench for laser_pkt_responder: random packets from a reference model,
// with a scoreboard monitor for FTDI writes, response bytes and status pulses.
module tb_laser_pkt_responder;

   logic       clock;
   logic       reset;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       tx_en;
   logic [7:0] tx_data;
   logic       tx_done;
   logic       pkt_ok;
   logic       pkt_fail;
   logic       session_done;

   int         n_vec = 0;
   int         n_miss = 0;
   logic [7:0] exp_wr[$];
   logic [7:0] exp_tx[$];
   int         exp_ev[$];      // 1 = pkt_ok, 2 = pkt_fail
   logic [7:0] pkt_q[$];
   bit         exp_sess = 1'b0;
   bit         rdy_rand = 1'b0;

   laser_pkt_responder dut (
      .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done),
      .pkt_ok(pkt_ok), .pkt_fail(pkt_fail), .session_done(session_done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation still running (required finish)");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic miss(input string name, input logic [31:0] act);
      n_vec++;
      n_miss++;
      $display("FAIL %s: got 0x%0h with nothing expected", name, act);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_wr_valid"},     32'(wr_valid),     32'd0);
      check({tag, "_wr_data"},      32'(wr_data),      32'd0);
      check({tag, "_tx_en"},        32'(tx_en),        32'd0);
      check({tag, "_tx_data"},      32'(tx_data),      32'd0);
      check({tag, "_pkt_ok"},       32'(pkt_ok),       32'd0);
      check({tag, "_pkt_fail"},     32'(pkt_fail),     32'd0);
      check({tag, "_session_done"}, 32'(session_done), 32'd0);
   endtask

   task automatic rx_byte(input logic [7:0] b, input int gap);
      repeat (gap) step();
      rx_valid = 1'b1;
      rx_data  = b;
      step();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   // Packet builder: header, payload (incrementing or random), optional checksum.
   task automatic build_pkt(input logic [7:0] hdr, input bit rnd, input bit corrupt);
      int         len;
      logic [7:0] b;
      logic [7:0] x;
      len = (hdr == 8'hcc) ? 512 : 6;
      pkt_q.delete();
      pkt_q.push_back(hdr);
      x = hdr;
`ifdef LASER_RESP_CHECKSUM_EN
      for (int i = 1; i < len - 1; i++) begin
         b = rnd ? 8'($urandom_range(255, 0)) : 8'(i);
         pkt_q.push_back(b);
         x = x ^ b;
      end
      pkt_q.push_back(corrupt ? (x ^ 8'h01) : x);
`else
      for (int i = 1; i < len; i++) begin
         b = rnd ? 8'($urandom_range(255, 0)) : 8'(i);
         pkt_q.push_back(b);
         x = x ^ b;
      end
      if (corrupt) pkt_q[len - 1] = ~x;
`endif
   endtask

   // Reference model: what a whole packet must produce on each interface.
   task automatic model_pkt();
      int         nfwd;
      bit         ok;
      logic [7:0] rb;
      int         rn;
`ifdef LASER_RESP_CHECKSUM_EN
      logic [7:0] x;
      x = 8'h00;
      foreach (pkt_q[i]) x = x ^ pkt_q[i];
      ok   = (x == 8'h00);
      nfwd = pkt_q.size() - 2;
`else
      ok   = 1'b1;
      nfwd = pkt_q.size() - 1;
`endif
      if (pkt_q[0] == 8'hcc) exp_sess = 1'b0;
      if (ok) begin
         for (int i = 1; i <= nfwd; i++) exp_wr.push_back(pkt_q[i]);
         exp_ev.push_back(1);
         if (pkt_q[0] == 8'h55) begin
            rb = 8'haa; rn = 2; exp_sess = 1'b1;
         end else begin
            rb = 8'h11; rn = 4;
         end
      end else begin
         exp_ev.push_back(2);
         rb = 8'hbb; rn = 4;
      end
      repeat (rn) exp_tx.push_back(rb);
   endtask

   task automatic send_pkt(input int max_gap);
      foreach (pkt_q[i]) rx_byte(pkt_q[i], int'($urandom_range(max_gap, 0)));
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_wr.size() != 0 || exp_tx.size() != 0 || exp_ev.size() != 0 || tx_en) && n < budget) begin
         step();
         n++;
      end
      n_vec++;
      if (n >= budget) begin
         n_miss++;
         $display("FAIL %s_complete: busy after %0d cycles, left wr=%0d tx=%0d ev=%0d (required 0)",
                  name, n, exp_wr.size(), exp_tx.size(), exp_ev.size());
         exp_wr.delete(); exp_tx.delete(); exp_ev.delete();
      end
      check({name, "_session_done"}, 32'(session_done), 32'(exp_sess));
   endtask

   // FTDI side: always ready, or randomly stalling.
   initial begin
      wr_ready = 1'b1;
      forever begin
         step();
         wr_ready = rdy_rand ? ($urandom_range(1, 0) == 1) : 1'b1;
      end
   end

   // Laser transmitter model: tx_done a few cycles after each request, plus stray strobes when idle.
   initial begin
      int gap;
      tx_done = 1'b0;
      gap = 0;
      forever begin
         step();
         tx_done = 1'b0;
         if (tx_en) begin
            if (gap == 0) begin
               tx_done = 1'b1;
               gap = int'($urandom_range(3, 0));
            end else begin
               gap--;
            end
         end else begin
            tx_done = ($urandom_range(7, 0) == 0);
            gap = int'($urandom_range(2, 0));
         end
      end
   end

   // Scoreboard monitor, sampled on the falling edge.
   initial begin
      logic       hold_pend;
      logic [7:0] hold_data;
      hold_pend = 1'b0;
      hold_data = 8'h00;
      forever begin
         @(negedge clock);
         if (reset) begin
            hold_pend = 1'b0;
         end else begin
            if (hold_pend) begin
               check("wr_stall_valid", 32'(wr_valid), 32'd1);
               check("wr_stall_data", 32'(wr_data), 32'(hold_data));
            end
            hold_pend = wr_valid && !wr_ready;
            hold_data = wr_data;
            if (wr_valid && wr_ready) begin
               if (exp_wr.size() == 0) miss("wr_extra", 32'(wr_data));
               else check("wr_data", 32'(wr_data), 32'(exp_wr.pop_front()));
            end
            if (tx_en && tx_done) begin
               if (exp_tx.size() == 0) miss("tx_extra", 32'(tx_data));
               else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
            if (pkt_ok || pkt_fail) begin
               if (exp_ev.size() == 0) miss("pkt_event_extra", 32'({pkt_fail, pkt_ok}));
               else check("pkt_event", 32'({pkt_fail, pkt_ok}), 32'(exp_ev.pop_front()));
            end
         end
      end
   end

   initial begin
      int         n;
      logic [7:0] hdr;
      logic [7:0] junk;
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) step();
      chk_zero("reset");
      reset = 1'b0;

      // Non-header bytes in IDLE are ignored; the STOP that follows is framed.
      rx_byte(8'h00, 1);
      rx_byte(8'h7f, 1);
      build_pkt(8'h55, 1'b0, 1'b0);
      model_pkt();
      send_pkt(2);
      wait_idle("stop_inc", 300);

      // START with an incrementing payload while FTDI stalls randomly.
      rdy_rand = 1'b1;
      build_pkt(8'hcc, 1'b0, 1'b0);
      model_pkt();
      send_pkt(1);
      wait_idle("start_inc", 4000);

      // Header plus 10 bytes, then silence: FAIL after exactly 1024 idle cycles.
      pkt_q.delete();
      pkt_q.push_back(8'hcc);
      for (int i = 0; i < 10; i++) pkt_q.push_back(8'($urandom_range(255, 0)));
      exp_ev.push_back(2);
      repeat (4) exp_tx.push_back(8'hbb);
      exp_sess = 1'b0;
      send_pkt(2);
      n = 0;
      while (!pkt_fail && n < 1200) begin
         step();
         n++;
      end
      check("timeout_cycles", 32'(n), 32'd1024);
      wait_idle("timeout", 200);

`ifdef LASER_RESP_CHECKSUM_EN
      // Wrong checksum on a STOP packet.
      pkt_q = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h54};
      model_pkt();
      send_pkt(1);
      wait_idle("bad_cksum", 300);
`endif

      // Random packets, junk in IDLE, and stray bytes while busy.
      for (int k = 0; k < 8; k++) begin
         hdr = ($urandom_range(2, 0) == 0) ? 8'hcc : 8'h55;
         if ($urandom_range(1, 0) == 1) begin
            junk = 8'($urandom_range(255, 0));
            if (junk == 8'h55 || junk == 8'hcc) junk = 8'h00;
            rx_byte(junk, 1);
         end
         build_pkt(hdr, 1'b1, ($urandom_range(3, 0) == 0));
         model_pkt();
         send_pkt(2);
         if ($urandom_range(1, 0) == 1) rx_byte(8'hcc, 0);
         wait_idle("rand", 4000);
      end

      // Reset in the middle of RECV: outputs clear and no late FAIL appears.
      rx_byte(8'h55, 0);
      rx_byte(8'h01, 0);
      rx_byte(8'h02, 0);
      reset = 1'b1;
      step();
      chk_zero("rst_recv");
      reset = 1'b0;
      exp_sess = 1'b0;
      repeat (1100) step();

      // Reset while a response is being transmitted.
      build_pkt(8'h55, 1'b0, 1'b0);
      model_pkt();
      send_pkt(0);
      n = 0;
      while (!tx_en && n < 2000) begin
         step();
         n++;
      end
      check("resp_started", 32'(tx_en), 32'd1);
      reset = 1'b1;
      step();
      chk_zero("rst_resp");
      reset = 1'b0;
      exp_wr.delete(); exp_tx.delete(); exp_ev.delete();
      exp_sess = 1'b0;
      repeat (5) step();

      // Normal operation resumes after the aborted response.
      build_pkt(8'h55, 1'b1, 1'b0);
      model_pkt();
      send_pkt(1);
      wait_idle("after_rst", 300);

      repeat (5) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
